taxi_qsfp_mod_ctrl: RTL and testbench

// Per-cage QSFP28 module management sequencer, replacing constant tie-offs on reset_n/lp_mode.

---
 rtl/taxi_qsfp_mod_ctrl.sv | 170 +++++++++++++++++
 tb/tb_taxi_qsfp_mod_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/taxi_qsfp_mod_ctrl.sv
// Per-cage QSFP28 management sequencer: presence debounce, timed module reset/init,
// low-power control and MAC reset hold-off until the module is ready.
module taxi_qsfp_mod_ctrl #(
    parameter int CNT             = 2,
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int RESET_CYCLES    = 1250,
    parameter int INIT_CYCLES     = 250000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [CNT-1:0] qsfp_mod_prsnt_n,
    input  logic [CNT-1:0] qsfp_intr_n,
    output logic [CNT-1:0] qsfp_reset_n,
    output logic [CNT-1:0] qsfp_lp_mode,
    input  logic [CNT-1:0] cfg_lp_mode_req,
    input  logic [CNT-1:0] cfg_reset_req,
    output logic [CNT-1:0] mac_rst_req,
    output logic [CNT-1:0] status_present,
    output logic [CNT-1:0] status_ready,
    output logic [CNT-1:0] status_intr
);

    localparam int MAX_CYCLES = (RESET_CYCLES > INIT_CYCLES) ? RESET_CYCLES : INIT_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);
    localparam int DW         = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [TW-1:0] RESET_LOAD = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] INIT_LOAD  = TW'(INIT_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ABSENT = 2'd0,
        ST_RESET  = 2'd1,
        ST_INIT   = 2'd2,
        ST_READY  = 2'd3
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < CNT; gi++) begin : g_cage
            logic          prsnt_s1_q, prsnt_s2_q;
            logic          intr_s1_q, intr_s2_q;
            logic          intr_q;
            logic          present_q;
            logic [DW-1:0] db_cnt_q;
            state_t        state_q, state_d;
            logic [TW-1:0] timer_q, timer_d;
            logic          reset_n_q, reset_n_d;
            logic          lp_mode_q, lp_mode_d;
            logic          mac_rst_q, mac_rst_d;
            logic          ready_q, ready_d;

            // Synchronizers idle at 1: module absent, no interrupt pending.
            always_ff @(posedge clk) begin
                if (rst) begin
                    prsnt_s1_q <= 1'b1;
                    prsnt_s2_q <= 1'b1;
                    intr_s1_q  <= 1'b1;
                    intr_s2_q  <= 1'b1;
                    intr_q     <= 1'b0;
                end else begin
                    prsnt_s1_q <= qsfp_mod_prsnt_n[gi];
                    prsnt_s2_q <= prsnt_s1_q;
                    intr_s1_q  <= qsfp_intr_n[gi];
                    intr_s2_q  <= intr_s1_q;
                    intr_q     <= ~intr_s2_q;
                end
            end

            // Presence flips only after a mismatch persists DEBOUNCE_CYCLES cycles in a row.
            always_ff @(posedge clk) begin
                if (rst) begin
                    present_q <= 1'b0;
                    db_cnt_q  <= '0;
                end else if (~prsnt_s2_q != present_q) begin
                    if (db_cnt_q == DB_LAST) begin
                        present_q <= ~present_q;
                        db_cnt_q  <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DW'(1);
                    end
                end else begin
                    db_cnt_q <= '0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_ABSENT;
                    timer_q <= '0;
                end else begin
                    state_q <= state_d;
                    timer_q <= timer_d;
                end
            end

            always_comb begin
                state_d = state_q;
                timer_d = timer_q;
                if (!present_q) begin
                    state_d = ST_ABSENT;
                    timer_d = '0;
                end else begin
                    case (state_q)
                        ST_ABSENT: begin
                            state_d = ST_RESET;
                            timer_d = RESET_LOAD;
                        end
                        ST_RESET: begin
                            if (cfg_reset_req[gi]) begin
                                timer_d = RESET_LOAD;
                            end else if (timer_q == '0) begin
                                state_d = ST_INIT;
                                timer_d = INIT_LOAD;
                            end else begin
                                timer_d = timer_q - TW'(1);
                            end
                        end
                        ST_INIT: begin
                            if (cfg_reset_req[gi]) begin
                                state_d = ST_RESET;
                                timer_d = RESET_LOAD;
                            end else if (timer_q == '0) begin
                                state_d = ST_READY;
                            end else begin
                                timer_d = timer_q - TW'(1);
                            end
                        end
                        default: begin
                            if (cfg_reset_req[gi]) begin
                                state_d = ST_RESET;
                                timer_d = RESET_LOAD;
                            end
                        end
                    endcase
                end
            end

            // Outputs decode the next state so they move on the same edge as the state.
            always_comb begin
                reset_n_d = (state_d == ST_INIT) || (state_d == ST_READY);
                lp_mode_d = (state_d == ST_READY) ? cfg_lp_mode_req[gi] : 1'b1;
                mac_rst_d = (state_d != ST_READY);
                ready_d   = (state_d == ST_READY);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    reset_n_q <= 1'b0;
                    lp_mode_q <= 1'b1;
                    mac_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                end else begin
                    reset_n_q <= reset_n_d;
                    lp_mode_q <= lp_mode_d;
                    mac_rst_q <= mac_rst_d;
                    ready_q   <= ready_d;
                end
            end

            assign qsfp_reset_n[gi]   = reset_n_q;
            assign qsfp_lp_mode[gi]   = lp_mode_q;
            assign mac_rst_req[gi]    = mac_rst_q;
            assign status_present[gi] = present_q;
            assign status_ready[gi]   = ready_q;
            assign status_intr[gi]    = intr_q;
        end
    endgenerate

endmodule

// File: tb/tb_taxi_qsfp_mod_ctrl.sv
// Directed bench for taxi_qsfp_mod_ctrl with short debounce/reset/init windows.
module tb_taxi_qsfp_mod_ctrl;

    localparam int CNT = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [CNT-1:0] qsfp_mod_prsnt_n;
    logic [CNT-1:0] qsfp_intr_n;
    logic [CNT-1:0] qsfp_reset_n;
    logic [CNT-1:0] qsfp_lp_mode;
    logic [CNT-1:0] cfg_lp_mode_req;
    logic [CNT-1:0] cfg_reset_req;
    logic [CNT-1:0] mac_rst_req;
    logic [CNT-1:0] status_present;
    logic [CNT-1:0] status_ready;
    logic [CNT-1:0] status_intr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    taxi_qsfp_mod_ctrl #(
        .CNT             (CNT),
        .DEBOUNCE_CYCLES (4),
        .RESET_CYCLES    (8),
        .INIT_CYCLES     (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .qsfp_mod_prsnt_n (qsfp_mod_prsnt_n),
        .qsfp_intr_n      (qsfp_intr_n),
        .qsfp_reset_n     (qsfp_reset_n),
        .qsfp_lp_mode     (qsfp_lp_mode),
        .cfg_lp_mode_req  (cfg_lp_mode_req),
        .cfg_reset_req    (cfg_reset_req),
        .mac_rst_req      (mac_rst_req),
        .status_present   (status_present),
        .status_ready     (status_ready),
        .status_intr      (status_intr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset0();
        cfg_reset_req = 2'b01;
        tick(1);
        cfg_reset_req = 2'b00;
    endtask

    // Insertion already started (synced input goes low on the first edge): walk the 31-cycle sequence.
    task automatic insertion_seq(input string tag);
        tick(5);
        check_eq({tag, "_present_c5"}, 32'(status_present), 32'h0);
        tick(1);
        check_eq({tag, "_present_c6"}, 32'(status_present), 32'h1);
        check_eq({tag, "_reset_n_c6"}, 32'(qsfp_reset_n), 32'h0);
        tick(8);
        check_eq({tag, "_reset_n_c14"}, 32'(qsfp_reset_n), 32'h0);
        tick(1);
        check_eq({tag, "_reset_n_c15"}, 32'(qsfp_reset_n), 32'h1);
        check_eq({tag, "_lp_c15"}, 32'(qsfp_lp_mode), 32'h3);
        tick(15);
        check_eq({tag, "_ready_c30"}, 32'(status_ready), 32'h0);
        check_eq({tag, "_mac_c30"}, 32'(mac_rst_req), 32'h3);
        tick(1);
        check_eq({tag, "_ready_c31"}, 32'(status_ready), 32'h1);
        check_eq({tag, "_mac_c31"}, 32'(mac_rst_req), 32'h2);
        check_eq({tag, "_lp_c31"}, 32'(qsfp_lp_mode), 32'h2);
        check_eq({tag, "_present_c31"}, 32'(status_present), 32'h1);
        $display("insertion %s: sequence walked to ready", tag);
    endtask

    initial begin
        logic ready_seen;

        rst              = 1'b1;
        qsfp_mod_prsnt_n = 2'b11;
        qsfp_intr_n      = 2'b11;
        cfg_lp_mode_req  = 2'b00;
        cfg_reset_req    = 2'b00;
        tick(3);
        check_eq("rst_reset_n", 32'(qsfp_reset_n), 32'h0);
        check_eq("rst_lp", 32'(qsfp_lp_mode), 32'h3);
        check_eq("rst_mac", 32'(mac_rst_req), 32'h3);
        check_eq("rst_present", 32'(status_present), 32'h0);
        check_eq("rst_ready", 32'(status_ready), 32'h0);
        check_eq("rst_intr", 32'(status_intr), 32'h0);
        rst = 1'b0;
        tick(2);
        $display("reset: outputs at reset values");

        // 3-cycle glitch stays below the debounce window
        qsfp_mod_prsnt_n = 2'b10;
        tick(3);
        qsfp_mod_prsnt_n = 2'b11;
        tick(10);
        check_eq("glitch_present", 32'(status_present), 32'h0);
        check_eq("glitch_reset_n", 32'(qsfp_reset_n), 32'h0);
        $display("glitch: presence held off");

        // Insertion, with an lp request during INIT that must be ignored
        qsfp_mod_prsnt_n = 2'b10;
        tick(15);
        check_eq("ins_reset_n_c15", 32'(qsfp_reset_n), 32'h1);
        cfg_lp_mode_req = 2'b01;
        tick(2);
        check_eq("init_lp_ignored", 32'(qsfp_lp_mode), 32'h3);
        cfg_lp_mode_req = 2'b00;
        tick(13);
        check_eq("ins_ready_c30", 32'(status_ready), 32'h0);
        tick(1);
        check_eq("ins_ready_c31", 32'(status_ready), 32'h1);
        check_eq("ins_mac_c31", 32'(mac_rst_req), 32'h2);
        check_eq("ins_lp_c31", 32'(qsfp_lp_mode), 32'h2);
        check_eq("ins_cage1_present", 32'(status_present), 32'h1);
        $display("insertion: cage0 ready at cycle 31");

        // LP follow in READY
        cfg_lp_mode_req = 2'b01;
        check_eq("lp_before_edge", 32'(qsfp_lp_mode), 32'h2);
        tick(1);
        check_eq("lp_follow_1", 32'(qsfp_lp_mode), 32'h3);
        cfg_lp_mode_req = 2'b00;
        tick(1);
        check_eq("lp_follow_0", 32'(qsfp_lp_mode), 32'h2);
        $display("lp_mode: follows request in ready");

        // Interrupt, cage 1
        qsfp_intr_n = 2'b01;
        tick(2);
        check_eq("intr_c2", 32'(status_intr), 32'h0);
        tick(1);
        check_eq("intr_c3", 32'(status_intr), 32'h2);
        qsfp_intr_n = 2'b11;
        tick(3);
        check_eq("intr_clear", 32'(status_intr), 32'h0);
        $display("interrupt: 3-cycle latency");

        // Software reset from READY
        pulse_reset0();
        check_eq("sw_reset_n", 32'(qsfp_reset_n), 32'h0);
        check_eq("sw_ready", 32'(status_ready), 32'h0);
        check_eq("sw_mac", 32'(mac_rst_req), 32'h3);
        check_eq("sw_lp", 32'(qsfp_lp_mode), 32'h3);
        tick(7);
        check_eq("sw_reset_n_c7", 32'(qsfp_reset_n), 32'h0);
        tick(1);
        check_eq("sw_reset_n_c8", 32'(qsfp_reset_n), 32'h1);
        tick(15);
        check_eq("sw_ready_c23", 32'(status_ready), 32'h0);
        tick(1);
        check_eq("sw_ready_c24", 32'(status_ready), 32'h1);
        $display("sw_reset: 8-cycle reset, ready after 24");

        // Second pulse mid-RESET restarts the window
        pulse_reset0();
        tick(3);
        pulse_reset0();
        tick(7);
        check_eq("restart_reset_n_c7", 32'(qsfp_reset_n), 32'h0);
        tick(1);
        check_eq("restart_reset_n_c8", 32'(qsfp_reset_n), 32'h1);
        tick(16);
        check_eq("restart_ready_c24", 32'(status_ready), 32'h1);
        $display("sw_reset: mid-reset pulse restarts window");

        // Removal during INIT
        pulse_reset0();
        tick(10);
        check_eq("rm_in_init", 32'(qsfp_reset_n), 32'h1);
        qsfp_mod_prsnt_n = 2'b11;
        ready_seen = 1'b0;
        tick(5);
        check_eq("rm_present_c5", 32'(status_present), 32'h1);
        tick(1);
        check_eq("rm_present_c6", 32'(status_present), 32'h0);
        tick(1);
        check_eq("rm_reset_n_c7", 32'(qsfp_reset_n), 32'h0);
        check_eq("rm_lp_c7", 32'(qsfp_lp_mode), 32'h3);
        check_eq("rm_mac_c7", 32'(mac_rst_req), 32'h3);
        for (int i = 0; i < 30; i++) begin
            tick(1);
            ready_seen = ready_seen | status_ready[0];
        end
        check_eq("rm_ready_never", 32'(ready_seen), 32'h0);
        $display("removal: cage0 back to absent");

        // Reinsert, then rst pulse while READY and repeat full sequence
        qsfp_mod_prsnt_n = 2'b10;
        insertion_seq("reins");
        rst = 1'b1;
        tick(1);
        check_eq("rstmid_reset_n", 32'(qsfp_reset_n), 32'h0);
        check_eq("rstmid_lp", 32'(qsfp_lp_mode), 32'h3);
        check_eq("rstmid_mac", 32'(mac_rst_req), 32'h3);
        check_eq("rstmid_present", 32'(status_present), 32'h0);
        check_eq("rstmid_ready", 32'(status_ready), 32'h0);
        rst = 1'b0;
        insertion_seq("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
